fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage pipelined datapath.
- Owns the program counter and the IF/ID pipeline register.
- Drives the instruction-memory address and feeds the decode stage (controller, register file, ID/EX register).
- Adds stall hold, branch redirect with squash, and a halt detector, replacing the free-running PC adder, PC register and IF/ID register.

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC and the IF/ID register, with stall hold,
// branch redirect/squash and halt detection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  state_t      state;
  if_id_t      if_id;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  assign target    = {branch_target[31:2], 2'b00};
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_id       <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_id <= '0;
          state <= RUN;
        end
        RUN: begin
          // Redirect wins over stall: the branch is older than whatever is stalling fetch.
          if (branch_taken) begin
            pc    <= target;
            if_id <= '0;
          end else if (stall) begin
            if_id <= if_id;
          end else if (imem_data == HALT_INSTR) begin
            if_id  <= '0;
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            pc          <= pc_plus4;
            if_id       <= '{instr: imem_data, pc_plus4: pc_plus4, valid: 1'b1};
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALTED: begin
          if_id <= '0;
          if (branch_taken) begin
            pc     <= target;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          if_id <= '0;
        end
      endcase
    end
  end

  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset/IDLE, normal fetch, stall, redirect, halt,
// PC wrap and asynchronous mid-cycle reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [0:63];
  int n_chk = 0, n_pass = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_p4, input logic e_vld, input logic e_halt,
                        input logic [31:0] e_cnt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".instr"}, if_id_instr, e_instr);
    chk({tag, ".p4"}, if_id_pc_plus4, e_p4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_vld});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    chk({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h2010_0005;
    mem[1] = 32'h2011_0007;

    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_st("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    // Release reset with a redirect pending: IDLE must ignore it.
    tick();
    rst = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    chk_st("idle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    branch_taken = 1'b0;

    tick(); chk_st("f0", 32'h4, 32'h2010_0005, 32'h4, 1'b1, 1'b0, 32'd1);
    tick(); chk_st("f1", 32'h8, 32'h2011_0007, 32'h8, 1'b1, 1'b0, 32'd2);
    tick(); tick();
    chk_st("f3", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 1'b0, 32'd4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_st("stall", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 1'b0, 32'd4);
    end
    stall = 1'b0;
    tick(); chk_st("unstall", 32'h14, 32'h1000_0004, 32'h14, 1'b1, 1'b0, 32'd5);
    tick(); tick(); tick();
    chk_st("f7", 32'h20, 32'h1000_0007, 32'h20, 1'b1, 1'b0, 32'd8);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043;
    tick(); chk_st("br_stall", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);

    stall = 1'b0; branch_target = 32'h30;
    mem[12] = 32'hFC00_0000;
    tick(); chk_st("br30", 32'h30, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
    branch_taken = 1'b0;
    tick(); chk_st("halt", 32'h30, 32'h0, 32'h0, 1'b0, 1'b1, 32'd8);
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      tick(); chk_st("halted", 32'h30, 32'h0, 32'h0, 1'b0, 1'b1, 32'd8);
    end
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h8;
    tick(); chk_st("unhalt", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
    branch_taken = 1'b0;
    tick(); chk_st("resume", 32'hC, 32'h1000_0002, 32'hC, 1'b1, 1'b0, 32'd9);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick(); chk_st("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd9);
    branch_taken = 1'b0;
    tick(); chk_st("wrap", 32'h0, 32'h1000_003F, 32'h0, 1'b1, 1'b0, 32'd10);

    branch_taken = 1'b1; branch_target = 32'h44;
    tick(); chk_st("br44", 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 32'd10);
    branch_taken = 1'b0;
    tick(); chk_st("f44", 32'h48, 32'h1000_0011, 32'h48, 1'b1, 1'b0, 32'd11);

    // Async reset between edges, with a redirect pending that must be discarded.
    branch_taken = 1'b1; branch_target = 32'h80;
    #1 rst = 1'b0;
    #1 chk_st("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    rst = 1'b1; branch_taken = 1'b0;
    tick(); chk_st("idle2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick(); chk_st("refetch", 32'h4, 32'h2010_0005, 32'h4, 1'b1, 1'b0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
